frogger_game_ctrl: RTL



---
 rtl/frogger_game_ctrl_if.sv | 35 +++
 rtl/frogger_game_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/frogger_game_ctrl_if.sv
// Frogger game-controller bus.
//   master : the side that produces frame/event/button activity (collision
//            logic, video timing, pad pins) and consumes game status
//   slave  : the game controller itself
// Signals:
//   frame_tick   1-cycle pulse per video frame (VSYNC start)
//   dpad_input   raw buttons {right, up, down, left}, asynchronous
//   collision    frog hit / drowned / off screen
//   reached_end  frog in goal row
//   state        00 TITLE, 01 PLAY, 10 DYING, 11 OVER
//   frog_respawn 1-cycle pulse: frog reloads its start position
//   lives        remaining lives
//   score        BCD {tens, ones}
//   hi_score     BCD {tens, ones}
interface frogger_game_ctrl_if;
  logic       frame_tick;
  logic [3:0] dpad_input;
  logic       collision;
  logic       reached_end;
  logic [1:0] state;
  logic       frog_respawn;
  logic [1:0] lives;
  logic [7:0] score;
  logic [7:0] hi_score;

  modport master (
    output frame_tick, dpad_input, collision, reached_end,
    input  state, frog_respawn, lives, score, hi_score
  );

  modport slave (
    input  frame_tick, dpad_input, collision, reached_end,
    output state, frog_respawn, lives, score, hi_score
  );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game-level controller.
// Sequences TITLE -> PLAY -> DYING -> (PLAY | OVER) -> TITLE, tracks lives,
// BCD score and BCD high score, and pulses frog_respawn whenever the frog
// must go back to its start position.
// Ports:
//   clk   pixel clock
//   reset asynchronous, active-high; clears everything including hi_score
//   bus   frogger_game_ctrl_if.slave (events/buttons in, game status out)
module frogger_game_ctrl #(
  parameter int START_LIVES  = 3,    // 1..3
  parameter int DEATH_FRAMES = 60,   // 1..255
  parameter int OVER_FRAMES  = 120   // 1..255
) (
  input  logic             clk,
  input  logic             reset,
  frogger_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    PLAY  = 2'b01,
    DYING = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] OVER_MAX   = 8'(OVER_FRAMES);

  state_t          st;
  logic            respawn_q;
  logic [1:0]      lives_q;
  logic [7:0]      score_q;
  logic [7:0]      hi_q;
  logic [7:0]      frame_cnt;

  // Button conditioning: 2-flop sync per bit, OR, registered rising edge.
  // Pin -> btn_press is 3 clocks.
  logic [1:0][3:0] sync;
  logic            any_btn;
  logic            any_q;
  logic            btn_press;

  assign any_btn = |sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= '0;
      any_q     <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync      <= {sync[0], bus.dpad_input};
      any_q     <= any_btn;
      btn_press <= any_btn & ~any_q;
    end
  end

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= TITLE;
      respawn_q <= 1'b0;
      lives_q   <= LIVES_INIT;
      score_q   <= 8'h00;
      hi_q      <= 8'h00;
      frame_cnt <= 8'd0;
    end else begin
      respawn_q <= 1'b0;
      case (st)
        // A simultaneous frame_tick is deliberately ignored here.
        TITLE: if (btn_press) begin
          st        <= PLAY;
          lives_q   <= LIVES_INIT;
          score_q   <= 8'h00;
          respawn_q <= 1'b1;
        end
        // Events are sampled once per frame; goal beats collision.
        PLAY: if (bus.frame_tick) begin
          if (bus.reached_end) begin
            score_q   <= bcd_inc(score_q);
            respawn_q <= 1'b1;
          end else if (bus.collision) begin
            st        <= DYING;
            frame_cnt <= 8'd0;
          end
        end
        // Collision is ignored here, so a held collision can't restart the timer.
        DYING: if (bus.frame_tick) begin
          if (frame_cnt == DEATH_LAST) begin
            if (lives_q > 2'd1) begin
              lives_q   <= lives_q - 2'd1;
              st        <= PLAY;
              respawn_q <= 1'b1;
            end else begin
              lives_q   <= 2'd0;
              st        <= OVER;
              frame_cnt <= 8'd0;
              if (score_q > hi_q) hi_q <= score_q;  // BCD order == binary order
            end
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        // Presses before the hold-off expires are simply dropped.
        OVER: begin
          if (btn_press && frame_cnt == OVER_MAX)
            st <= TITLE;
          else if (bus.frame_tick && frame_cnt != OVER_MAX)
            frame_cnt <= frame_cnt + 8'd1;
        end
        default: st <= TITLE;
      endcase
    end
  end

  assign bus.state        = st;
  assign bus.frog_respawn = respawn_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.hi_score     = hi_q;

endmodule
